load_store_unit: RTL

//  Memory stage fed by the EX-stage ALU: takes ALU_out as effective address plus rs2 store data,

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit_lane_align.sv | 53 +++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states,
// timeout default and the access legality rule.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_DONE
    } lsu_state_e;

    // Unsigned sizes have no store form; halves and words must be naturally aligned.
    function automatic logic lsu_illegal(input logic       is_load,
                                         input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = is_load & is_store;
        case (funct3)
            LSU_B:   ;
            LSU_H:   bad = bad | addr_lo[0];
            LSU_W:   bad = bad | (|addr_lo);
            LSU_BU:  bad = bad | is_store;
            LSU_HU:  bad = bad | is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and memory-side req/ack signals of the load/store unit.
interface load_store_unit_if #(parameter int unsigned n = 32);

    logic         start;
    logic         is_load;
    logic         is_store;
    logic [2:0]   funct3;
    logic [n-1:0] addr;
    logic [n-1:0] wdata_in;
    logic         stall;
    logic         done;
    logic         err;
    logic [n-1:0] load_data;
    logic         mem_req;
    logic         mem_we;
    logic [n-1:0] mem_addr;
    logic [n-1:0] mem_wdata;
    logic [3:0]   mem_be;
    logic         mem_ack;
    logic [n-1:0] mem_rdata;

    modport slave (
        input  start, is_load, is_store, funct3, addr, wdata_in, mem_ack, mem_rdata,
        output stall, done, err, load_data, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output start, is_load, is_store, funct3, addr, wdata_in, mem_ack, mem_rdata,
        input  stall, done, err, load_data, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store data replication and byte enables, load lane
// selection with sign/zero extension. Purely combinational, 32-bit lanes.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
        case (st_funct3_i)
            LSU_B: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_be_o    = 4'b0001 << st_addr_lo_i;
            end
            LSU_H: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    byte_sel = ld_word_i[7:0];
            2'd1:    byte_sel = ld_word_i[15:8];
            2'd2:    byte_sel = ld_word_i[23:16];
            default: byte_sel = ld_word_i[31:24];
        endcase
        half_sel = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_funct3_i)
            LSU_B:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   ld_data_o = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  ld_data_o = {24'h0, byte_sel};
            LSU_HU:  ld_data_o = {16'h0, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one outstanding access on a word-wide req/ack memory,
// stalling the pipeline until done and flagging illegal or timed-out accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned n       = 32,
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    lsu_state_e   state_q, state_d;
    logic         mem_we_q, mem_we_d;
    logic [n-1:0] mem_addr_q, mem_addr_d;
    logic [n-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]   mem_be_q, mem_be_d;
    logic [n-1:0] load_data_q, load_data_d;
    logic         err_q, err_d;
    logic         is_load_q, is_load_d;
    logic [2:0]   funct3_q, funct3_d;
    logic [1:0]   addr_lo_q, addr_lo_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic [n-1:0] st_wdata;
    logic [3:0]   st_be;
    logic [n-1:0] ld_data;

    // Store lanes come from the live request; load lanes from the captured one.
    lsu_lane_align u_align (
        .st_funct3_i  (bus.funct3),
        .st_addr_lo_i (bus.addr[1:0]),
        .st_data_i    (bus.wdata_in),
        .st_wdata_o   (st_wdata),
        .st_be_o      (st_be),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_word_i    (bus.mem_rdata),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        tmr_d       = tmr_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.start && (bus.is_load || bus.is_store)) begin
                    if (lsu_illegal(bus.is_load, bus.is_store, bus.funct3, bus.addr[1:0])) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = LSU_REQ;
                        err_d       = 1'b0;
                        mem_we_d    = bus.is_store;
                        mem_addr_d  = {bus.addr[n-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_be_d    = bus.is_store ? st_be : '0;
                        is_load_d   = bus.is_load;
                        funct3_d    = bus.funct3;
                        addr_lo_d   = bus.addr[1:0];
                        tmr_d       = '0;
                    end
                end
            end
            LSU_REQ: begin
                if (bus.mem_ack) begin
                    state_d = LSU_DONE;
                    if (is_load_q) load_data_d = ld_data;
                end else if (TIMEOUT != 0) begin
                    if (tmr_q == TMR_LAST) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LSU_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
            is_load_q   <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            tmr_q       <= tmr_d;
        end
    end

    assign bus.mem_req   = (state_q == LSU_REQ);
    assign bus.stall     = (state_q == LSU_REQ);
    assign bus.done      = (state_q == LSU_DONE);
    assign bus.err       = (state_q == LSU_DONE) & err_q;
    assign bus.load_data = load_data_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule
